dna_porte2: RTL and testbench



---
 rtl/dna_porte2.sv | 56 +++++
 tb/tb_dna_porte2.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dna_porte2.sv
// dna_porte2 - behavioural model of the FPGA device-DNA access port.
//
// Holds a fixed identifier (SIM_DNA_VALUE). READ loads it into an internal
// shift register; SHIFT moves the register toward the LSB with din_i entering
// at the MSB. dout_o always shows register bit 0, so the identifier is read
// LSB first: bit 0 right after the READ edge, then bit k after the k-th shift.
//
// Ports:
//   clk_i    - shift clock, rising edge active
//   rst_n_i  - asynchronous active-low reset, clears the shift register
//   din_i    - serial data shifted into the MSB end
//   read_i   - load SIM_DNA_VALUE (has priority over shift_i)
//   shift_i  - shift enable
//   dout_o   - serial data out, combinational copy of register bit 0

module dna_porte2 #(
   parameter int unsigned              DNA_WIDTH     = 96,
   parameter logic [DNA_WIDTH-1:0]     SIM_DNA_VALUE = '0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic din_i,
   input  logic read_i,
   input  logic shift_i,
   output logic dout_o
);

   // The shift expression below needs at least two register bits.
   if (DNA_WIDTH < 2) begin : g_width_check
      $error("dna_porte2: DNA_WIDTH must be at least 2");
   end

   logic [DNA_WIDTH-1:0] sr_q;
   logic [DNA_WIDTH-1:0] sr_d;

   // READ wins over SHIFT; with neither the register holds.
   always_comb begin
      sr_d = sr_q;
      if (read_i) begin
         sr_d = SIM_DNA_VALUE;
      end else if (shift_i) begin
         sr_d = {din_i, sr_q[DNA_WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign dout_o = sr_q[0];

endmodule

// File: tb/tb_dna_porte2.sv
// tb_dna_porte2 - directed self-checking bench for dna_porte2 with a 96-bit
// known identifier. Inputs change 1 time unit after a rising edge and dout_o is
// sampled at the same point, away from the active edge.

module tb_dna_porte2;

   localparam int unsigned    W   = 96;
   localparam logic [W-1:0]   DNA = 96'h76543210FEDCBA9876543210;

   logic clk;
   logic rst_n;
   logic din;
   logic rd;
   logic sh;
   logic dout;

   int checks;
   int failures;

   dna_porte2 #(
      .DNA_WIDTH     (W),
      .SIM_DNA_VALUE (DNA)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .din_i   (din),
      .read_i  (rd),
      .shift_i (sh),
      .dout_o  (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock edge with the given controls, then settle past the edge.
   task automatic step(input logic r, input logic s, input logic d);
      rd  = r;
      sh  = s;
      din = d;
      @(posedge clk);
      #1;
   endtask

   // READ edge followed by W-1 shifts; bit k is dout after shift k.
   task automatic read_all(output logic [W-1:0] v);
      step(1'b1, 1'b0, 1'b0);
      v[0] = dout;
      for (int k = 1; k < W; k++) begin
         step(1'b0, 1'b1, 1'b0);
         v[k] = dout;
      end
   endtask

   logic [W-1:0] v;
   logic [4:0]   first5;
   logic         ok;

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      din      = 1'b0;
      rd       = 1'b0;
      sh       = 1'b0;

      // Reset and first READ
      #2;
      check("reset_dout", {95'b0, dout}, '0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("pre_read_dout", {95'b0, dout}, '0);
      step(1'b1, 1'b0, 1'b0);
      check("read_bit0", {95'b0, dout}, {95'b0, DNA[0]});

      // Full readout
      read_all(v);
      check("full_readout", v, DNA);

      // READ + 4 shifts, then READ and SHIFT together must reload
      step(1'b1, 1'b0, 1'b0);
      first5[0] = dout;
      for (int k = 1; k < 5; k++) begin
         step(1'b0, 1'b1, 1'b0);
         first5[k] = dout;
      end
      check("first5_seq", {91'b0, first5}, {91'b0, 5'b10000});
      step(1'b1, 1'b1, 1'b1);
      check("read_shift_dout", {95'b0, dout}, '0);
      v[0] = dout;
      for (int k = 1; k < W; k++) begin
         step(1'b0, 1'b1, 1'b0);
         v[k] = dout;
      end
      check("read_wins_readout", v, DNA);

      // Fill with ones, then flush with zeros: exact W-shift delay
      step(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < W; k++) step(1'b0, 1'b1, 1'b1);
      check("ones_after_fill", {95'b0, dout}, {95'b0, 1'b1});
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, 1'b1);
         if (dout !== 1'b1) ok = 1'b0;
      end
      check("ones_keep", {95'b0, ok}, {95'b0, 1'b1});
      for (int k = 0; k < W - 1; k++) step(1'b0, 1'b1, 1'b0);
      check("flush_last_one", {95'b0, dout}, {95'b0, 1'b1});
      step(1'b0, 1'b1, 1'b0);
      check("flush_zero", {95'b0, dout}, '0);
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, 1'b0);
         if (dout !== 1'b0) ok = 1'b0;
      end
      check("flush_stays_zero", {95'b0, ok}, {95'b0, 1'b1});

      // Async reset mid-shift (41 shifts so dout is 1 before reset)
      step(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 41; k++) step(1'b0, 1'b1, 1'b0);
      check("pre_reset_bit41", {95'b0, dout}, {95'b0, DNA[41]});
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_dout", {95'b0, dout}, '0);
      step(1'b1, 1'b0, 1'b0);
      check("reset_ignores_read", {95'b0, dout}, '0);
      #2 rst_n = 1'b1;
      v = '0;
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b1, 1'b0);
         v[k] = dout;
      end
      check("post_reset_zeros", v, '0);
      read_all(v);
      check("post_reset_readout", v, DNA);

      // Idle hold with din high: nothing may move
      step(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
      check("idle_bit3", {95'b0, dout}, '0);
      ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 1'b0, 1'b1);
         if (dout !== 1'b0) ok = 1'b0;
      end
      check("idle_hold", {95'b0, ok}, {95'b0, 1'b1});
      step(1'b0, 1'b1, 1'b0);
      check("idle_then_bit4", {95'b0, dout}, {95'b0, 1'b1});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
